// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI receive deserializer.
package spi_rx_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned BIT_CNT_W = cnt_width(DATA_W_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_rx_deserializer_sync.sv
// Multi-flop synchronizer for one asynchronous input; reset value is selectable.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI mode-0 receive deserializer: oversamples sclk/cs_n/mosi in the clk domain
// and assembles MSB-first words, flagging frames cut short by cs_n release.
module spi_rx_deserializer
  import spi_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_valid,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int unsigned       CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_s;
  logic w_cs_n_s;
  logic w_mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (spi_sclk),
    .o_q    (w_sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (spi_cs_n),
    .o_q    (w_cs_n_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (spi_mosi),
    .o_q    (w_mosi_s)
  );

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sclk_d;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_word_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [15:0]       r_frame_count;
  logic [15:0]       w_count_nxt;
  logic              w_sclk_rise;
  logic              w_word_done;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_word_done = w_sclk_rise && (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_sclk_d      <= 1'b0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_word        <= '0;
      r_valid       <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_sclk_d      <= w_sclk_s;
      r_shift       <= w_shift_nxt;
      r_cnt         <= w_cnt_nxt;
      r_word        <= w_word_nxt;
      r_valid       <= w_valid_nxt;
      r_err         <= w_err_nxt;
      r_frame_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_count_nxt = r_frame_count;
    unique case (r_state)
      IDLE: begin
        if (!w_cs_n_s) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_shift_nxt = {r_shift[DATA_W-2:0], w_mosi_s};
          if (w_word_done) begin
            w_word_nxt  = {r_shift[DATA_W-2:0], w_mosi_s};
            w_valid_nxt = 1'b1;
            w_count_nxt = r_frame_count + 16'd1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        // A word completing in the same cycle as cs_n release is accepted, not an error.
        if (w_cs_n_s) begin
          w_state_nxt = IDLE;
          if (!w_word_done && (r_cnt != '0)) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_word     = r_word;
  assign rx_valid    = r_valid;
  assign frame_err   = r_err;
  assign frame_count = r_frame_count;

endmodule

// File: doc/spi_rx_deserializer.md
SPI_RX_DESERIALIZER -- requirements
Module: spi_rx_deserializer

Interface
REQ-001 SHALL have parameter: DATA_W, 16, frame/word width in bits.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, synchronizer flops per async input (min 2).
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: spi_sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 SHALL have port: spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port: spi_mosi  input  1  SPI serial data, MSB first, asynchronous.
REQ-008 SHALL have port: rx_word  output  DATA_W  last complete received word; drives the 16-bit PIO in_port.
REQ-009 SHALL have port: rx_valid  output  1  one-cycle pulse when rx_word is updated.
REQ-010 SHALL have port: frame_err  output  1  one-cycle pulse on short frame (CS released mid-word).
REQ-011 SHALL have port: frame_count  output  16  count of complete words received, wraps.

Function
REQ-012 SHALL pass spi_sclk, spi_cs_n, spi_mosi each through a SYNC_STAGES-flop synchronizer before use.
REQ-013 SHALL detect a sclk rising edge as synchronized sclk high while its one-cycle-delayed copy is low (SPI mode 0: sample on rising edge).
REQ-014 SHALL implement FSM states IDLE and SHIFT; reset state IDLE.
REQ-015 IDLE -> SHIFT when synchronized cs_n is low; bit counter and shift register cleared on entry.
REQ-016 In SHIFT, each detected sclk rising edge SHALL shift synchronized mosi into shift register LSB (left shift) and increment bit counter.
REQ-017 When the edge carrying bit index DATA_W-1 is detected, rx_word SHALL load {shift[DATA_W-2:0], mosi} on that same clk edge, rx_valid SHALL be high that cycle only, frame_count SHALL increment, bit counter SHALL return to 0, state stays SHIFT.
REQ-018 Multiple consecutive words within one CS assertion SHALL each produce their own rx_valid.
REQ-019 SHIFT -> IDLE when synchronized cs_n is high; if bit counter != 0 at that time, frame_err SHALL pulse one cycle and rx_word, frame_count SHALL be unchanged.
REQ-020 Simultaneous completing sclk edge and cs_n release in one cycle: word SHALL be accepted (rx_valid pulse), frame_err SHALL NOT pulse.
REQ-021 sclk edges while IDLE SHALL be ignored.
REQ-022 rx_word SHALL hold its value between updates; no readback clear.
REQ-023 frame_count SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-024 Latency raw sclk edge -> rx_valid SHALL be SYNC_STAGES+1 clk cycles (±1 for sampling phase).
REQ-025 Correct operation SHALL require f_clk >= 8 x f_sclk; mosi stable around sclk rising edge per mode 0.

Reset
REQ-026 On reset_n low, asynchronously: state IDLE, shift register 0, bit counter 0, rx_word 0, rx_valid 0, frame_err 0, frame_count 0, synchronizer flops to 1 for cs_n and 0 for sclk/mosi.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after release the block SHALL wait for cs_n high->low sequence only via REQ-015 (no spurious rx_valid, no frame_err).

Structure
REQ-028 Package spi_rx_pkg SHALL hold DATA_W default, state enum type (IDLE, SHIFT), and bit-counter width constant $clog2(DATA_W).
REQ-029 Sub-module spi_sync (parameterized SYNC_STAGES, reset value parameter) SHALL be instantiated once per async input.
REQ-030 No other sub-modules; rx_word connects directly to the downstream PIO in_port.

Verification
REQ-031 Reset, send 16'hA5C3 in one CS frame at sclk = clk/10 -> one rx_valid, rx_word=16'hA5C3, frame_count=1, no frame_err.
REQ-032 Two words 16'h1234, 16'hFFFF under one CS assertion -> two rx_valid pulses, rx_word ends 16'hFFFF, frame_count=2.
REQ-033 Send 9 bits then release CS -> frame_err one pulse, rx_word keeps previous value, frame_count unchanged.
REQ-034 Toggle sclk with cs_n high (16 edges of 16'hBEEF) -> no rx_valid, rx_word unchanged.
REQ-035 Assert reset_n low after 8 bits, release, send 16'h0F0F -> rx_word=16'h0F0F, frame_count=1, no frame_err.
REQ-036 Preload frame_count to 16'hFFFF via 65535 frames (or force) then one frame -> frame_count=16'h0000, rx_valid pulses.
